// File: rtl/spr_pkg.sv
// Shared definitions for the Alpha68k sprite line-buffer path: widths, the
// transparent pixel code, the scheduler FSM states and priming depth.
package spr_pkg;

    localparam int W_X_DEF  = 8;
    localparam int W_C_DEF  = 8;
    localparam int C_TRANSP = 0;

    // Two swaps after reset before a display buffer holds rendered data.
    localparam logic [1:0] PRIME_FULL = 2'd2;

    typedef enum logic {
        RUN,
        SWAP
    } state_t;

    function automatic logic [1:0] prime_step(input logic [1:0] cnt);
        return (cnt == PRIME_FULL) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/linebuf_ram.sv
// Single-port synchronous line buffer. One access per cycle; a write returns
// the previous contents, so the display side reads and clears in one access.
module linebuf_ram
    import spr_pkg::*;
#(
    parameter int W_X = W_X_DEF,
    parameter int W_C = W_C_DEF
) (
    input  logic           clk,
    input  logic           en,
    input  logic           we,
    input  logic [W_X-1:0] addr,
    input  logic [W_C-1:0] wdata,
    output logic [W_C-1:0] rdata
);

    localparam int DEPTH = 1 << W_X;

    logic [W_C-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset; a RAM macro cannot
    // be cleared in one cycle, and stale contents are masked by priming.
    // NOTE: sequential state is always written with <= so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/spr_linebuf_ctrl.sv
// Sprite line-buffer scheduler: ping-pongs two line buffers each scanline,
// filling one from the sprite engine while reading out and clearing the other.
module spr_linebuf_ctrl
    import spr_pkg::*;
#(
    parameter int W_X = W_X_DEF,
    parameter int W_C = W_C_DEF
) (
    input  logic           clk,
    input  logic           nRESET,
    input  logic           ce_pix,
    input  logic           line_start,
    input  logic           hflip,
    input  logic           rend_valid,
    output logic           rend_ready,
    input  logic [W_X-1:0] rend_x,
    input  logic [W_C-1:0] rend_c,
    input  logic           rend_done,
    output logic [W_C-1:0] pix_out,
    output logic           pix_valid,
    output logic           bflip,
    output logic           rend_late,
    input  logic           late_clr
);

    state_t         state;
    state_t         state_nxt;
    logic           swap;
    logic           active_q;
    logic           hflip_s;
    logic           flip_q;
    logic           done_q;
    logic           disp_act;
    logic           clr_pend;
    logic           rd_valid;
    logic [W_X-1:0] disp_x;
    logic [1:0]     prime_cnt;

    logic           rend_wr;
    logic           disp_rd;
    logic [W_X-1:0] rend_addr;

    logic           a_en;
    logic           b_en;
    logic [W_X-1:0] a_addr;
    logic [W_X-1:0] b_addr;
    logic [W_C-1:0] a_wdata;
    logic [W_C-1:0] b_wdata;
    logic [W_C-1:0] a_rdata;
    logic [W_C-1:0] b_rdata;
    logic [W_C-1:0] disp_rdata;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        rend_ready = 1'b0;
        swap       = 1'b0;
        case (state)
            RUN: begin
                rend_ready = active_q;
                if (line_start) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                swap      = 1'b1;
                state_nxt = RUN;
            end
        endcase
    end

    assign rend_wr   = rend_valid && rend_ready && (rend_c != W_C'(C_TRANSP));
    assign rend_addr = flip_q ? ~rend_x : rend_x;
    assign disp_rd   = ce_pix && disp_act && (state == RUN) && !line_start;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            active_q  <= 1'b0;
            hflip_s   <= 1'b0;
            flip_q    <= 1'b0;
            bflip     <= 1'b0;
            done_q    <= 1'b0;
            rend_late <= 1'b0;
            disp_act  <= 1'b0;
            disp_x    <= '0;
            clr_pend  <= 1'b0;
            rd_valid  <= 1'b0;
            prime_cnt <= '0;
            pix_valid <= 1'b0;
            pix_out   <= '0;
        end else begin
            active_q <= 1'b1;
            clr_pend <= disp_rd;
            rd_valid <= clr_pend;

            if (line_start) begin
                hflip_s <= hflip;
            end

            // Read-and-clear access has just completed: advance the beam.
            if (clr_pend) begin
                disp_x <= disp_x + 1'b1;
                if (disp_x == '1) begin
                    disp_act <= 1'b0;
                end
            end

            if (rend_done) begin
                done_q <= 1'b1;
            end
            if (late_clr) begin
                rend_late <= 1'b0;
            end

            // Later assignments win: the swap overrides the beam and the done
            // flag, and a late condition overrides late_clr.
            if (swap) begin
                bflip     <= ~bflip;
                flip_q    <= hflip_s;
                disp_x    <= '0;
                disp_act  <= 1'b1;
                prime_cnt <= prime_step(prime_cnt);
                done_q    <= 1'b0;
                if (!done_q) begin
                    rend_late <= 1'b1;
                end
            end

            pix_valid <= rd_valid && (prime_cnt == PRIME_FULL);
            pix_out   <= (rd_valid && (prime_cnt == PRIME_FULL)) ? disp_rdata : '0;
        end
    end

    // bflip = 0: buffer A displays, buffer B renders.
    assign a_en       = bflip ? rend_wr : clr_pend;
    assign a_addr     = bflip ? rend_addr : disp_x;
    assign a_wdata    = bflip ? rend_c : '0;
    assign b_en       = bflip ? clr_pend : rend_wr;
    assign b_addr     = bflip ? disp_x : rend_addr;
    assign b_wdata    = bflip ? '0 : rend_c;
    assign disp_rdata = bflip ? b_rdata : a_rdata;

    linebuf_ram #(
        .W_X (W_X),
        .W_C (W_C)
    ) u_ram_a (
        .clk   (clk),
        .en    (a_en),
        .we    (1'b1),
        .addr  (a_addr),
        .wdata (a_wdata),
        .rdata (a_rdata)
    );

    linebuf_ram #(
        .W_X (W_X),
        .W_C (W_C)
    ) u_ram_b (
        .clk   (clk),
        .en    (b_en),
        .we    (1'b1),
        .addr  (b_addr),
        .wdata (b_wdata),
        .rdata (b_rdata)
    );

endmodule

// File: tb/tb_spr_linebuf_ctrl.sv
// Directed bench for spr_linebuf_ctrl: a buffer model predicts each displayed
// pixel into a scoreboard queue that a negedge monitor drains and compares.
module tb_spr_linebuf_ctrl;

    localparam int DEPTH = 256;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       ce_pix = 1'b0;
    logic       line_start = 1'b0;
    logic       hflip = 1'b0;
    logic       rend_valid = 1'b0;
    logic [7:0] rend_x = '0;
    logic [7:0] rend_c = '0;
    logic       rend_done = 1'b0;
    logic       late_clr = 1'b0;
    logic       rend_ready;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       bflip;
    logic       rend_late;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Model state; buffer entries of -1 are unknown (never written or cleared).
    int   mdl[2][DEPTH];
    logic m_bflip;
    logic m_flip;
    logic m_late;
    logic m_done;
    logic m_dact;
    int   m_prime;
    int   m_dx;

    always #5 clk = ~clk;

    spr_linebuf_ctrl #(
        .W_X (8),
        .W_C (8)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .ce_pix     (ce_pix),
        .line_start (line_start),
        .hflip      (hflip),
        .rend_valid (rend_valid),
        .rend_ready (rend_ready),
        .rend_x     (rend_x),
        .rend_c     (rend_c),
        .rend_done  (rend_done),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .bflip      (bflip),
        .rend_late  (rend_late),
        .late_clr   (late_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_bflip = 1'b0;
        m_flip  = 1'b0;
        m_late  = 1'b0;
        m_done  = 1'b0;
        m_dact  = 1'b0;
        m_prime = 0;
        m_dx    = 0;
    endtask

    task automatic mdl_write(input int x, input int c);
        int a;
        a = m_flip ? (DEPTH - 1 - x) : x;
        if (c != 0) mdl[m_bflip ? 0 : 1][a] = c;
    endtask

    task automatic rend_px(input int x, input int c);
        rend_valid = 1'b1;
        rend_x     = 8'(x);
        rend_c     = 8'(c);
        check("ready_rend", rend_ready, 1);
        tick();
        rend_valid = 1'b0;
        mdl_write(x, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bflip"}, bflip, 0);
        check({tag, "_ready"}, rend_ready, 0);
        check({tag, "_pix_out"}, pix_out, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_late"}, rend_late, 0);
    endtask

    // Line start pulse plus the SWAP cycle; hflip changes during SWAP so only
    // the value presented with line_start may be used.
    task automatic do_line(input logic hf, input logic dn, input logic lclr, input logic hold);
        line_start = 1'b1;
        hflip      = hf;
        rend_done  = dn;
        if (hold) begin
            rend_valid = 1'b1;
            rend_x     = 8'd30;
            rend_c     = 8'h77;
        end
        check("ready_ls", rend_ready, 1);
        tick();
        if (hold) mdl_write(30, 'h77);
        line_start = 1'b0;
        rend_done  = 1'b0;
        hflip      = ~hf;
        late_clr   = lclr;
        if (hold) begin
            rend_x = 8'd31;
            rend_c = 8'h78;
        end
        check("ready_swap", rend_ready, 0);
        tick();
        late_clr = 1'b0;
        m_done   = m_done | dn;
        m_bflip  = ~m_bflip;
        m_flip   = hf;
        if (m_prime < 2) m_prime++;
        if (!m_done) m_late = 1'b1;
        else if (lclr) m_late = 1'b0;
        m_done = 1'b0;
        m_dact = 1'b1;
        m_dx   = 0;
        check("bflip", bflip, m_bflip);
        check("rend_late", rend_late, m_late);
        check("ready_run", rend_ready, 1);
        if (hold) begin
            rend_x = 8'd32;
            rend_c = 8'h79;
            tick();
            mdl_write(32, 'h79);
            rend_valid = 1'b0;
        end
    endtask

    task automatic disp(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_dact) begin
                if (m_prime == 2) sb.push_back('{m_dx, mdl[m_bflip ? 1 : 0][m_dx]});
                mdl[m_bflip ? 1 : 0][m_dx] = 0;
                m_dx++;
                if (m_dx == DEPTH) begin
                    m_dx   = 0;
                    m_dact = 1'b0;
                end
            end
            ce_pix = 1'b1;
            tick();
            ce_pix = 1'b0;
            tick();
        end
    endtask

    task automatic drain();
        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (nRESET) begin
            if (pix_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", pix_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.val >= 0) check($sformatf("pix_out[%0d]", mon_e.idx), pix_out, mon_e.val);
                end
            end else begin
                check("pix_out_idle", pix_out, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) mdl[b][a] = -1;
        model_reset();

        // Reset values, then rend_ready rises after release.
        nRESET = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        nRESET = 1'b1;
        tick();
        check("ready_after_rst", rend_ready, 1);

        // Priming: line 0 (inactive) and line 1 (prime 1) show nothing.
        disp(8);
        drain();
        do_line(1'b0, 1'b0, 1'b0, 1'b0);
        disp(DEPTH);
        drain();

        // On-time done with line_start keeps the sticky late flag; then clear it.
        do_line(1'b0, 1'b1, 1'b0, 1'b0);
        late_clr = 1'b1;
        tick();
        late_clr = 1'b0;
        m_late   = 1'b0;
        check("late_clr", rend_late, 0);

        // Render into B while A (unknown contents) is displayed and cleared.
        rend_px(5, 'h3A);
        rend_px(9, 'h11);
        rend_px(9, 'h00);
        rend_done = 1'b1;
        tick();
        rend_done = 1'b0;
        m_done    = 1'b1;
        disp(DEPTH);
        drain();

        // Line 3: B shows 0x3A at 5 and 0x11 at 9; render flipped into A.
        do_line(1'b1, 1'b0, 1'b0, 1'b0);
        rend_px(0, 'h44);
        disp(DEPTH);
        drain();

        // Line 4: missing done with late_clr in SWAP sets late; A shows 0x44 at 255.
        do_line(1'b0, 1'b0, 1'b1, 1'b0);
        disp(DEPTH);
        drain();

        // Line 5: rend_valid held through line_start; B was cleared, x=5 reads 0.
        do_line(1'b0, 1'b1, 1'b0, 1'b1);
        disp(DEPTH);
        drain();

        // Line 6: reset mid-line at disp_x = 100 while a pixel is valid.
        do_line(1'b0, 1'b1, 1'b0, 1'b0);
        disp(100);
        tick();
        check("pv_before_rst", pix_valid, 1);
        nRESET = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        model_reset();
        tick();
        nRESET = 1'b1;
        tick();
        check("ready_after_midrst", rend_ready, 1);

        // After reset priming restarts, so the next line shows no pixels.
        do_line(1'b0, 1'b1, 1'b0, 1'b0);
        disp(16);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
